// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RISC-V datapath: sequences lw/sw/R-type/I-type/beq/jal
// and decodes the ALU control, immediate format and PC write enable.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     state;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;

    // Unused state encodings fall through to the default and recover to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTER;
                        OP_ITYPE:     state <= S_EXECUTEI;
                        OP_BEQ:       state <= S_BEQ;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_JAL:      state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_op    = 2'b00;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract only for R-type with funct7b5 set; addi with that bit set remains an add.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected control vectors are queued
// per cycle as instructions are driven and compared at the falling edge.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;

    typedef struct packed {
        logic [1:0] imm;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [1:0] res;
        logic       adr;
        logic [2:0] aluc;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
    } ctrl_t;

    typedef enum {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_JAL, P_ALUWB, P_BEQ
    } phase_t;

    typedef struct {
        string tag;
        ctrl_t c;
    } sb_entry_t;

    sb_entry_t sbq[$];
    int        checkCount;
    int        passCount;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference control values written directly from the state/output table.
    function automatic ctrl_t expCtrl(phase_t p, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
        ctrl_t c;
        logic [2:0] arith;
        c = '0;
        if (o == 7'b0100011)      c.imm = 2'b01;
        else if (o == 7'b1100011) c.imm = 2'b10;
        else if (o == 7'b1101111) c.imm = 2'b11;
        if (f3 == 3'b010)      arith = 3'b101;
        else if (f3 == 3'b110) arith = 3'b011;
        else if (f3 == 3'b111) arith = 3'b010;
        else if (f3 == 3'b000 && o == 7'b0110011 && f7) arith = 3'b001;
        else arith = 3'b000;
        case (p)
            P_FETCH:    begin c.irw = 1; c.pcw = 1; c.srcB = 2'b10; c.res = 2'b10; end
            P_DECODE:   begin c.srcA = 2'b01; c.srcB = 2'b01; end
            P_MEMADR:   begin c.srcA = 2'b10; c.srcB = 2'b01; end
            P_MEMREAD:  c.adr = 1;
            P_MEMWB:    begin c.res = 2'b01; c.rw = 1; end
            P_MEMWRITE: begin c.adr = 1; c.mw = 1; end
            P_EXECR:    begin c.srcA = 2'b10; c.aluc = arith; end
            P_EXECI:    begin c.srcA = 2'b10; c.srcB = 2'b01; c.aluc = arith; end
            P_JAL:      begin c.srcA = 2'b01; c.srcB = 2'b10; c.pcw = 1; end
            P_ALUWB:    c.rw = 1;
            P_BEQ:      begin c.srcA = 2'b10; c.aluc = 3'b001; c.pcw = z; end
            default:    ;
        endcase
        return c;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction; abortAt >= 0 asserts reset during that phase index.
    task automatic applyStimulus(input string name, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input int abortAt);
        phase_t    seq[$];
        sb_entry_t e;
        seq = '{P_FETCH, P_DECODE};
        case (o)
            7'b0000011: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
            7'b0100011: begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWRITE); end
            7'b0110011: begin seq.push_back(P_EXECR); seq.push_back(P_ALUWB); end
            7'b0010011: begin seq.push_back(P_EXECI); seq.push_back(P_ALUWB); end
            7'b1100011: seq.push_back(P_BEQ);
            7'b1101111: begin seq.push_back(P_JAL); seq.push_back(P_ALUWB); end
            default:    ;
        endcase
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        for (int i = 0; i < seq.size(); i++) begin
            e.tag = $sformatf("%s.%0d", name, i);
            e.c   = expCtrl(seq[i], o, f3, f7, z);
            sbq.push_back(e);
            if (i == abortAt) begin
                reset = 1'b1;
                stepCycle();
                reset = 1'b0;
                return;
            end
            stepCycle();
        end
    endtask

    always @(negedge clk) begin
        sb_entry_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput(e.tag, {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                                IRWrite, PCWrite, RegWrite, MemWrite}, e.c);
        end
    end

    initial begin
        logic [6:0] opList [7];
        checkCount = 0;
        passCount  = 0;
        opList = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};
        reset    = 1'b1;
        op       = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b0;

        applyStimulus("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        applyStimulus("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, -1);
        applyStimulus("sub",      7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        applyStimulus("add",      7'b0110011, 3'b000, 1'b0, 1'b0, -1);
        applyStimulus("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        applyStimulus("slt",      7'b0110011, 3'b010, 1'b0, 1'b0, -1);
        applyStimulus("or",       7'b0110011, 3'b110, 1'b0, 1'b0, -1);
        applyStimulus("and",      7'b0110011, 3'b111, 1'b0, 1'b0, -1);
        applyStimulus("slti",     7'b0010011, 3'b010, 1'b0, 1'b0, -1);
        applyStimulus("xor_f3",   7'b0110011, 3'b100, 1'b1, 1'b0, -1);
        applyStimulus("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        applyStimulus("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        applyStimulus("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, -1);
        applyStimulus("illegal",  7'b0000000, 3'b000, 1'b0, 1'b0, -1);
        applyStimulus("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 3);
        applyStimulus("post_rst", 7'b0000011, 3'b010, 1'b0, 1'b1, -1);

        for (int n = 0; n < 20; n++) begin
            applyStimulus($sformatf("rnd%0d", n), opList[$urandom_range(0, 6)],
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), -1);
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        checkOutput("drain", 16'(sbq.size()), 16'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
